// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-carry adder/subtractor, one CW-bit slice per stage
// Optional PIPELINED_ADDER_SAT_EN: signed saturation of sum on overflow.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic en;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic [CW:0]      part [STAGES];

  logic             msb_cin;
  logic             ovf_nx;
  logic [WIDTH-1:0] sum_nx;
  logic             unused_sink;

  assign en        = !v_q[L] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign cout      = c_q[L];
  assign ovf       = ovf_q;

  // Stage k sees the operands of stage k-1 (skew) and adds only its own slice.
  always_comb begin
    a_in[0] = a;
    b_in[0] = b ^ {WIDTH{sub}};
    c_in[0] = sub | cin;
    v_in[0] = in_valid & en;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
      s_in[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
              + {{CW{1'b0}}, c_in[k]};
      s_nx[k] = s_in[k];
      s_nx[k][k*CW +: CW] = part[k][CW-1:0];
    end
  end

  // Carry into the MSB recovered from the MSB sum bit and its operand bits.
  always_comb begin
    msb_cin = a_in[L][WIDTH-1] ^ b_in[L][WIDTH-1] ^ s_nx[L][WIDTH-1];
    ovf_nx  = msb_cin ^ part[L][CW];
`ifdef PIPELINED_ADDER_SAT_EN
    if (ovf_nx) begin
      sum_nx = a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum_nx = s_nx[L];
    end
`else
    sum_nx = s_nx[L];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= (k == L) ? sum_nx : s_nx[k];
        c_q[k] <= part[k][CW];
        v_q[k] <= v_in[k];
      end
      ovf_q <= ovf_nx;
    end
  end

  // Consumed operand bits below each slice and the last skew stage are dead.
  always_comb begin
    unused_sink = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      unused_sink = unused_sink ^ (^a_q[k]) ^ (^b_q[k]);
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=16, STAGES=4)
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int vectors = 0;
  int miscompares = 0;

  // Reference pipeline: four slots of fully computed results.
  bit          mv [4];
  logic [15:0] ms [4];
  bit          mc [4];
  bit          mo [4];

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ref_op(input logic [15:0] ta, tb, input bit tcin, tsub);
    int unsigned bb, ci, full;
    int sa, sb, r;
    logic [15:0] s;
    bit c, o;
    bb   = tsub ? (~{16'h0, tb} & 32'hFFFF) : {16'h0, tb};
    ci   = tsub ? 1 : {31'h0, tcin};
    full = {16'h0, ta} + bb + ci;
    s    = full[15:0];
    c    = full[16];
    sa   = $signed(ta);
    sb   = $signed(bb[15:0]);
    r    = sa + sb + int'(ci);
    o    = (r > 32767) || (r < -32768);
`ifdef PIPELINED_ADDER_SAT_EN
    if (o) s = ta[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {o, c, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rn, input bit iv, input logic [15:0] ta, input logic [15:0] tb,
                      input bit tcin, input bit tsub, input bit tor);
    bit en_m;
    logic [17:0] r;
    rst_n = rn; in_valid = iv; a = ta; b = tb; cin = tcin; sub = tsub; out_ready = tor;
    #1;
    en_m = !mv[3] || tor;
    check("in_ready", {31'h0, in_ready}, {31'h0, en_m});
    check("out_valid", {31'h0, out_valid}, {31'h0, mv[3]});
    if (mv[3]) begin
      check("sum", {16'h0, sum}, {16'h0, ms[3]});
      check("cout", {31'h0, cout}, {31'h0, mc[3]});
      check("ovf", {31'h0, ovf}, {31'h0, mo[3]});
    end
    if (!rn) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = 1'b0; ms[i] = '0; mc[i] = 1'b0; mo[i] = 1'b0;
      end
    end else if (en_m) begin
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i-1]; ms[i] = ms[i-1]; mc[i] = mc[i-1]; mo[i] = mo[i-1];
      end
      r = ref_op(ta, tb, tcin, tsub);
      mv[0] = iv; ms[0] = r[15:0]; mc[0] = r[16]; mo[0] = r[17];
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic directed(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input bit tcin, input bit tsub,
                          input logic [15:0] es, input bit ec, input bit eo);
    step(1'b1, 1'b1, ta, tb, tcin, tsub, 1'b1);
    idle(); idle();
    check({tag, "_early"}, {31'h0, out_valid}, 32'h0);
    idle();
    check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
    check({tag, "_sum"}, {16'h0, sum}, {16'h0, es});
    check({tag, "_cout"}, {31'h0, cout}, {31'h0, ec});
    check({tag, "_ovf"}, {31'h0, ovf}, {31'h0, eo});
    idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; ms[i] = '0; mc[i] = 1'b0; mo[i] = 1'b0;
    end
    @(negedge clk);
    step(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_sum", {16'h0, sum}, 32'h0);
    check("rst_cout", {31'h0, cout}, 32'h0);
    check("rst_ovf", {31'h0, ovf}, 32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    idle(); idle(); idle(); idle();

    directed("basic", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
`ifdef PIPELINED_ADDER_SAT_EN
    directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    directed("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
    directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Back-to-back: 8 accepts, results stream out on consecutive cycles.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) idle();

    // Backpressure: hold out_ready low for 3 cycles once a result is present.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) idle();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_sum", {16'h0, sum}, 32'h0);
    check("mid_rst_cout", {31'h0, cout}, 32'h0);
    check("mid_rst_ovf", {31'h0, ovf}, 32'h0);
    for (int i = 0; i < 6; i++) idle();
    directed("post_rst", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 7));
    for (int i = 0; i < 8; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
